// File: rtl/ddr3_req_arbiter_if.sv
// Request/command bundle between the read/write request ports, the arbiter and the DDR3 sequencer.
// Signal names keep the arbiter-side _i/_o direction suffixes on both modports.
interface ddr3_req_arbiter_if #(
    parameter int unsigned ADDRS        = 32,
    parameter int unsigned MEM_ID_WIDTH = 4
);
    logic                    wr_req_i;
    logic                    wr_ack_o;
    logic                    wr_lst_i;
    logic [MEM_ID_WIDTH-1:0] wr_tid_i;
    logic [ADDRS-1:0]        wr_adr_i;

    logic                    rd_req_i;
    logic                    rd_ack_o;
    logic                    rd_lst_i;
    logic [MEM_ID_WIDTH-1:0] rd_tid_i;
    logic [ADDRS-1:0]        rd_adr_i;

    logic                    cmd_valid_o;
    logic                    cmd_ready_i;
    logic                    cmd_write_o;
    logic                    cmd_last_o;
    logic [MEM_ID_WIDTH-1:0] cmd_tid_o;
    logic [ADDRS-1:0]        cmd_adr_o;

    modport slave (
        input  wr_req_i, wr_lst_i, wr_tid_i, wr_adr_i,
        input  rd_req_i, rd_lst_i, rd_tid_i, rd_adr_i,
        input  cmd_ready_i,
        output wr_ack_o, rd_ack_o,
        output cmd_valid_o, cmd_write_o, cmd_last_o, cmd_tid_o, cmd_adr_o
    );

    modport master (
        output wr_req_i, wr_lst_i, wr_tid_i, wr_adr_i,
        output rd_req_i, rd_lst_i, rd_tid_i, rd_adr_i,
        output cmd_ready_i,
        input  wr_ack_o, rd_ack_o,
        input  cmd_valid_o, cmd_write_o, cmd_last_o, cmd_tid_o, cmd_adr_o
    );
endinterface

// File: rtl/ddr3_req_arbiter.sv
// Read/write request arbiter feeding a single-register DDR3 command stage; sequences never interleave.
// Define DDR3_ARB_STARVE_EN to enable the write-starvation override (WR_STARVE_LIMIT); otherwise read always wins in IDLE.
module ddr3_req_arbiter #(
    parameter int unsigned ADDRS           = 32,
    parameter int unsigned MEM_ID_WIDTH    = 4,
    parameter int unsigned WR_STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    ddr3_req_arbiter_if.slave     arb
);

    if (WR_STARVE_LIMIT < 1 || WR_STARVE_LIMIT > 255) begin : g_bad_limit
        $error("WR_STARVE_LIMIT must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_SEQ = 2'd1,
        WR_SEQ = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    cmd_valid_q, cmd_valid_d;
    logic                    cmd_write_q, cmd_write_d;
    logic                    cmd_last_q,  cmd_last_d;
    logic [MEM_ID_WIDTH-1:0] cmd_tid_q,   cmd_tid_d;
    logic [ADDRS-1:0]        cmd_adr_q,   cmd_adr_d;

    logic free_c;
    logic starve_hit_c;
    logic rd_ok_c, wr_ok_c;
    logic wr_pick_c, rd_pick_c;
    logic wr_ack_c, rd_ack_c;

`ifdef DDR3_ARB_STARVE_EN
    localparam logic [7:0] STARVE_LIM = 8'(WR_STARVE_LIMIT);

    logic [7:0] starve_q, starve_d;

    // Counts reads granted past a waiting write; saturates at the limit.
    always_comb begin
        starve_d = starve_q;
        if (wr_ack_c || !arb.wr_req_i) begin
            starve_d = 8'd0;
        end else if (rd_ack_c && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_q <= 8'd0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign starve_hit_c = (starve_q == STARVE_LIM);
`else
    assign starve_hit_c = 1'b0;
`endif

    // Grant uses only inputs and registered state; cmd_ready_i enters only via the free test.
    always_comb begin
        free_c    = !cmd_valid_q || arb.cmd_ready_i;
        rd_ok_c   = arb.rd_req_i && (state_q != WR_SEQ);
        wr_ok_c   = arb.wr_req_i && (state_q != RD_SEQ);
        wr_pick_c = wr_ok_c && (!rd_ok_c || starve_hit_c);
        rd_pick_c = rd_ok_c && !wr_pick_c;
        wr_ack_c  = !reset && free_c && wr_pick_c;
        rd_ack_c  = !reset && free_c && rd_pick_c;
    end

    // Sequence tracking: a lst=0 ack locks the arbiter to that port until its lst=1 ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rd_ack_c && !arb.rd_lst_i) begin
                    state_d = RD_SEQ;
                end else if (wr_ack_c && !arb.wr_lst_i) begin
                    state_d = WR_SEQ;
                end
            end
            RD_SEQ: begin
                if (rd_ack_c && arb.rd_lst_i) begin
                    state_d = IDLE;
                end
            end
            WR_SEQ: begin
                if (wr_ack_c && arb.wr_lst_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output stage: load on ack, drop valid after a handshake with nothing new, otherwise hold.
    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_write_d = cmd_write_q;
        cmd_last_d  = cmd_last_q;
        cmd_tid_d   = cmd_tid_q;
        cmd_adr_d   = cmd_adr_q;
        if (wr_ack_c) begin
            cmd_valid_d = 1'b1;
            cmd_write_d = 1'b1;
            cmd_last_d  = arb.wr_lst_i;
            cmd_tid_d   = arb.wr_tid_i;
            cmd_adr_d   = arb.wr_adr_i;
        end else if (rd_ack_c) begin
            cmd_valid_d = 1'b1;
            cmd_write_d = 1'b0;
            cmd_last_d  = arb.rd_lst_i;
            cmd_tid_d   = arb.rd_tid_i;
            cmd_adr_d   = arb.rd_adr_i;
        end else if (arb.cmd_ready_i) begin
            cmd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_valid_q <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_last_q  <= 1'b0;
            cmd_tid_q   <= '0;
            cmd_adr_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_write_q <= cmd_write_d;
            cmd_last_q  <= cmd_last_d;
            cmd_tid_q   <= cmd_tid_d;
            cmd_adr_q   <= cmd_adr_d;
        end
    end

    assign arb.wr_ack_o    = wr_ack_c;
    assign arb.rd_ack_o    = rd_ack_c;
    assign arb.cmd_valid_o = cmd_valid_q;
    assign arb.cmd_write_o = cmd_write_q;
    assign arb.cmd_last_o  = cmd_last_q;
    assign arb.cmd_tid_o   = cmd_tid_q;
    assign arb.cmd_adr_o   = cmd_adr_q;

endmodule
